instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the 23-bit MIPS-style processor; sits directly upstream of `instruction_field` and drives its 23-bit `instruction` input. Holds the program counter, an internal instruction memory with a program-load port, and a small control FSM for start, stall, redirect (branch/jump) and halt. Delivers one registered instruction per cycle with a valid flag and its PC.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: instruction words; power of two.
- `PC_W`, 8: PC width; equals log2(`IMEM_DEPTH`).
- `RESET_PC`, 0: PC value loaded on reset.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start_i`, in, 1: one-cycle pulse; leaves IDLE.
- `stall_i`, in, 1: downstream not ready; hold all state.
- `redirect_i`, in, 1: load PC from `redirect_pc_i`, flush the in-flight slot.
- `redirect_pc_i`, in, `PC_W`: redirect target.
- `prog_we_i`, in, 1: instruction memory write enable.
- `prog_addr_i`, in, `PC_W`: write address.
- `prog_data_i`, in, 23: write data.
- `instr_o`, out, 23: fetched instruction to `instruction_field`.
- `instr_valid_o`, out, 1: `instr_o` and `pc_o` are meaningful.
- `pc_o`, out, `PC_W`: address `instr_o` was fetched from.
- `halted_o`, out, 1: FSM in HALT.

## Operation
- Instruction format: opcode[22:18], regD[17:16], regS[15:14], regT[13:12], offset[11:0]. `HALT_OP` = 5'd31.
- FSM states: IDLE, FETCH, HALT.
- IDLE: `instr_valid_o`=0. `start_i` -> FETCH. `redirect_i` loads PC; FSM stays in IDLE unless `start_i` is also high, in which case it goes to FETCH with the new PC.
- FETCH, `!stall_i`, `!redirect_i`:
  - `instr_o` <= mem[pc].
  - `pc_o` <= pc.
  - `instr_valid_o` <= 1.
  - pc <= pc+1, modulo `IMEM_DEPTH`; wraps from `IMEM_DEPTH`-1 to 0.
  - If mem[pc][22:18] == `HALT_OP`: the HALT word is still emitted with valid, then FSM -> HALT and pc does not increment.
- FETCH, `stall_i` (no redirect): `instr_o`, `pc_o`, `instr_valid_o`, pc and state all hold.
- `redirect_i` in FETCH or HALT:
  - pc <= `redirect_pc_i`.
  - `instr_valid_o` <= 0 for one bubble cycle.
  - FSM -> FETCH.
  - Redirect takes priority over `stall_i`.
- HALT: `instr_valid_o`=0 from the cycle after the HALT word, unless a stall is holding it. `halted_o`=1. Only `redirect_i` or reset exits.
- Memory writes are accepted in any state. Same-cycle write and fetch at the same address returns the old word (read-before-write). Memory contents are not reset.

## Timing
- Reset (async assert, sync-safe deassert), all outputs: `instr_o`=0, `instr_valid_o`=0, `pc_o`=0, `halted_o`=0. Internal pc=`RESET_PC`, state=IDLE.
- Latency: `start_i` high at edge N -> first valid instruction (pc=`RESET_PC`) visible after edge N+1.
- Throughput: one instruction per unstalled cycle.
- Redirect at edge N -> bubble (valid=0) after N -> target instruction valid after N+1.
- Reset asserted mid-FETCH clears outputs immediately, without waiting for a clock edge.

## Structure
- Package `instr_pkg`:
  - `INSTR_W`=23, `OPCODE_W`=5, `REG_W`=2, `OFFSET_W`=12.
  - Field bit positions.
  - `HALT_OP`.
  - FSM state enum `fetch_state_t`.
  - Shared with `instruction_field`.
- Sub-module `instr_mem`: `IMEM_DEPTH` x 23 array, asynchronous read, synchronous write port. All PC/FSM logic stays in `instr_fetch`.

## Test plan
- Load words 0..3 = 23'h0B9000, 23'h04C050, 23'h000001, 23'h7C0000 (opcode 31), then pulse `start_i` -> valid outputs pc 0,1,2,3 on consecutive cycles; `halted_o`=1 after pc 3; valid=0 thereafter.
- Assert `stall_i` for 3 cycles while pc_o=1 -> `instr_o`=23'h04C050 and valid held for 3 cycles; then pc 2 follows with no skip and no duplicate.
- `redirect_i` with target 8'h40 while fetching pc 5 -> one bubble cycle, then pc_o=8'h40; pc 6 is never emitted valid.
- Redirect and stall in the same cycle -> redirect wins: bubble, then target instruction.
- Start at pc 8'hFE with no HALT words -> emits 8'hFE, 8'hFF, 8'h00 (wrap-around).
- Drop `rst_n` between clock edges mid-FETCH -> outputs zero immediately; after release, FSM is in IDLE and waits for `start_i`.

Source files
------------

// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// instr_pkg : instruction format, HALT opcode and fetch FSM states
// Rev 1.0
// ============================================================================
package instr_pkg;

    localparam int INSTR_W    = 23;
    localparam int OPCODE_W   = 5;
    localparam int REG_W      = 2;
    localparam int OFFSET_W   = 12;

    localparam int OPCODE_MSB = 22;
    localparam int OPCODE_LSB = 18;
    localparam int REGD_MSB   = 17;
    localparam int REGD_LSB   = 16;
    localparam int REGS_MSB   = 15;
    localparam int REGS_LSB   = 14;
    localparam int REGT_MSB   = 13;
    localparam int REGT_LSB   = 12;
    localparam int OFFSET_MSB = 11;
    localparam int OFFSET_LSB = 0;

    localparam logic [OPCODE_W-1:0] HALT_OP = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem.sv
`default_nettype none
// ============================================================================
// instr_mem : IMEM_DEPTH x 23 instruction store, async read, sync write
// Rev 1.0
// ============================================================================
module instr_mem
    import instr_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int PC_W       = 8
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PC_W-1:0]    waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [PC_W-1:0]    raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [IMEM_DEPTH];

    // Contents are deliberately not reset; the combinational read sees the
    // pre-write word when a write and fetch hit the same address.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : PC, instruction memory and start/stall/redirect/halt control
// Rev 1.0
// ============================================================================
module instr_fetch
    import instr_pkg::*;
#(
    parameter int              IMEM_DEPTH = 256,
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    input  logic               prog_we_i,
    input  logic [PC_W-1:0]    prog_addr_i,
    input  logic [INSTR_W-1:0] prog_data_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic               instr_valid_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               halted_o
);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] mem_rdata;

    instr_mem #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .PC_W       (PC_W)
    ) u_instr_mem (
        .clk     (clk),
        .we_i    (prog_we_i),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_data_i),
        .raddr_i (pc_q),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    instr_d  = mem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    // The HALT word is emitted, but the PC parks on it
                    if (get_opcode(mem_rdata) == HALT_OP) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        instr_o       = instr_q;
        pc_o          = pc_out_q;
        instr_valid_o = valid_q;
        halted_o      = (state_q == ST_HALT);
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed scenarios plus random traffic against a reference
// Rev 1.0
// ============================================================================
module tb_instr_fetch;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [7:0]  redirect_pc_i = '0;
    logic        prog_we_i = 1'b0;
    logic [7:0]  prog_addr_i = '0;
    logic [22:0] prog_data_i = '0;
    logic [22:0] instr_o;
    logic        instr_valid_o;
    logic [7:0]  pc_o;
    logic        halted_o;

    instr_fetch #(
        .IMEM_DEPTH (DEPTH),
        .PC_W       (8),
        .RESET_PC   (8'h00)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .prog_we_i     (prog_we_i),
        .prog_addr_i   (prog_addr_i),
        .prog_data_i   (prog_data_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .pc_o          (pc_o),
        .halted_o      (halted_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: a program counter walking an array, with a running/halted flag
    logic [22:0] m_mem [DEPTH];
    int          m_pc;
    bit          m_run;
    bit          m_halt;
    logic [22:0] e_instr;
    logic [7:0]  e_pc;
    bit          e_valid;

    task automatic model_reset();
        m_pc = 0; m_run = 0; m_halt = 0;
        e_instr = '0; e_pc = '0; e_valid = 0;
    endtask

    task automatic model_step();
        logic [22:0] w;
        w = m_mem[m_pc];
        if (m_halt) begin
            if (redirect_i) begin
                m_pc = int'(redirect_pc_i); m_halt = 0; m_run = 1; e_valid = 0;
            end else if (!stall_i) begin
                e_valid = 0;
            end
        end else if (m_run) begin
            if (redirect_i) begin
                m_pc = int'(redirect_pc_i); e_valid = 0;
            end else if (!stall_i) begin
                e_instr = w; e_pc = 8'(m_pc); e_valid = 1;
                if (w[22:18] == 5'd31) begin
                    m_halt = 1; m_run = 0;
                end else begin
                    m_pc = (m_pc + 1) % DEPTH;
                end
            end
        end else begin
            if (redirect_i) m_pc = int'(redirect_pc_i);
            if (start_i) m_run = 1;
            e_valid = 0;
        end
        if (prog_we_i) m_mem[prog_addr_i] = prog_data_i;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [22:0] rand_word(input bit allow_halt);
        logic [22:0] w;
        w = 23'($urandom);
        if (allow_halt && $urandom_range(7) == 0) w[22:18] = 5'd31;
        else if (w[22:18] == 5'd31) w[22:18] = 5'd0;
        return w;
    endfunction

    task automatic load(input logic [7:0] a, input logic [22:0] d);
        prog_we_i = 1; prog_addr_i = a; prog_data_i = d;
        cyc();
        prog_we_i = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (instr_o !== 23'h0) begin errors++; $display("FAIL reset_instr got=%h want=0", instr_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", instr_valid_o); end
        checks++; if (pc_o !== 8'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", pc_o); end
        checks++; if (halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", halted_o); end
        @(negedge clk);
        rst_n = 1;
        for (int a = 0; a < DEPTH; a++) load(8'(a), rand_word(1));
        checks++;
        if (instr_valid_o !== 1'b0 || halted_o !== 1'b0) begin
            errors++; $display("FAIL idle_after_load valid=%b halted=%b want 0/0", instr_valid_o, halted_o);
        end
    endtask

    task automatic test_program();
        logic [22:0] prog [4];
        prog[0] = 23'h0B9000; prog[1] = 23'h04C050; prog[2] = 23'h000001; prog[3] = 23'h7C0000;
        for (int i = 0; i < 4; i++) load(8'(i), prog[i]);
        start_i = 1;
        cyc();
        start_i = 0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL start_latency valid=%b want=0", instr_valid_o); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (instr_valid_o !== 1'b1 || pc_o !== 8'(i) || instr_o !== prog[i] || halted_o !== (i == 3)) begin
                errors++;
                $display("FAIL program_seq%0d valid=%b pc=%h instr=%h halted=%b want 1/%h/%h/%b",
                         i, instr_valid_o, pc_o, instr_o, halted_o, 8'(i), prog[i], (i == 3));
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (instr_valid_o !== 1'b0 || halted_o !== 1'b1) begin
                errors++; $display("FAIL halt_hold valid=%b halted=%b want 0/1", instr_valid_o, halted_o);
            end
        end
    endtask

    task automatic test_stall();
        redirect_i = 1; redirect_pc_i = 8'h00;
        cyc();
        redirect_i = 0;
        checks++; if (instr_valid_o !== 1'b0 || halted_o !== 1'b0) begin errors++; $display("FAIL unhalt_bubble valid=%b halted=%b want 0/0", instr_valid_o, halted_o); end
        cyc(); cyc();
        checks++; if (pc_o !== 8'h01 || instr_valid_o !== 1'b1) begin errors++; $display("FAIL pre_stall pc=%h valid=%b want 01/1", pc_o, instr_valid_o); end
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (pc_o !== 8'h01 || instr_o !== 23'h04C050 || instr_valid_o !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d pc=%h instr=%h valid=%b want 01/04c050/1", i, pc_o, instr_o, instr_valid_o);
            end
        end
        stall_i = 0;
        cyc();
        checks++; if (pc_o !== 8'h02 || instr_o !== 23'h000001 || instr_valid_o !== 1'b1) begin errors++; $display("FAIL after_stall pc=%h instr=%h valid=%b want 02/000001/1", pc_o, instr_o, instr_valid_o); end
        cyc();
        checks++; if (pc_o !== 8'h03 || halted_o !== 1'b1) begin errors++; $display("FAIL stall_halt pc=%h halted=%b want 03/1", pc_o, halted_o); end
    endtask

    task automatic test_redirect();
        bit saw6;
        saw6 = 0;
        for (int a = 4; a < 7; a++) load(8'(a), rand_word(0));
        load(8'h40, rand_word(0));
        load(8'h41, rand_word(0));
        redirect_i = 1; redirect_pc_i = 8'h04;
        cyc();
        redirect_i = 0;
        cyc(); cyc();
        checks++; if (pc_o !== 8'h05 || instr_valid_o !== 1'b1) begin errors++; $display("FAIL redirect_setup pc=%h valid=%b want 05/1", pc_o, instr_valid_o); end
        redirect_i = 1; redirect_pc_i = 8'h40;
        cyc();
        redirect_i = 0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redirect_bubble valid=%b want=0", instr_valid_o); end
        if (instr_valid_o === 1'b1 && pc_o === 8'h06) saw6 = 1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (instr_valid_o === 1'b1 && pc_o === 8'h06) saw6 = 1;
            checks++;
            if (instr_valid_o !== 1'b1 || pc_o !== 8'(8'h40 + i) || instr_o !== m_mem[8'h40 + i]) begin
                errors++; $display("FAIL redirect_target%0d pc=%h instr=%h valid=%b want %h/%h/1",
                                   i, pc_o, instr_o, instr_valid_o, 8'(8'h40 + i), m_mem[8'h40 + i]);
            end
        end
        checks++; if (saw6) begin errors++; $display("FAIL redirect_shadow pc 06 emitted valid=1 want never"); end
    endtask

    task automatic test_redirect_stall();
        load(8'h10, rand_word(0));
        redirect_i = 1; stall_i = 1; redirect_pc_i = 8'h10;
        cyc();
        redirect_i = 0; stall_i = 0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redir_stall_bubble valid=%b want=0", instr_valid_o); end
        cyc();
        checks++;
        if (instr_valid_o !== 1'b1 || pc_o !== 8'h10 || instr_o !== m_mem[8'h10]) begin
            errors++; $display("FAIL redir_stall_target pc=%h instr=%h valid=%b want 10/%h/1", pc_o, instr_o, instr_valid_o, m_mem[8'h10]);
        end
    endtask

    task automatic test_mid_reset();
        @(posedge clk);
        model_step();
        #3;
        rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (instr_o !== 23'h0 || instr_valid_o !== 1'b0 || pc_o !== 8'h0 || halted_o !== 1'b0) begin
            errors++; $display("FAIL async_reset instr=%h valid=%b pc=%h halted=%b want all 0", instr_o, instr_valid_o, pc_o, halted_o);
        end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (instr_valid_o !== 1'b0 || halted_o !== 1'b0) begin
                errors++; $display("FAIL post_reset_idle%0d valid=%b halted=%b want 0/0", i, instr_valid_o, halted_o);
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] want [3];
        want[0] = 8'hFE; want[1] = 8'hFF; want[2] = 8'h00;
        load(8'hFE, rand_word(0));
        load(8'hFF, rand_word(0));
        load(8'h00, rand_word(0));
        redirect_i = 1; start_i = 1; redirect_pc_i = 8'hFE;
        cyc();
        redirect_i = 0; start_i = 0;
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL wrap_start valid=%b want=0", instr_valid_o); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (instr_valid_o !== 1'b1 || pc_o !== want[i] || instr_o !== m_mem[want[i]]) begin
                errors++; $display("FAIL wrap%0d pc=%h instr=%h valid=%b want %h/%h/1", i, pc_o, instr_o, instr_valid_o, want[i], m_mem[want[i]]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            start_i       = ($urandom_range(7) == 0);
            stall_i       = ($urandom_range(3) == 0);
            redirect_i    = ($urandom_range(9) == 0);
            redirect_pc_i = 8'($urandom);
            prog_we_i     = ($urandom_range(3) == 0);
            prog_addr_i   = ($urandom_range(1) == 0) ? 8'(m_pc) : 8'($urandom);
            prog_data_i   = rand_word(1);
            cyc();
            checks++;
            if (instr_valid_o !== e_valid || halted_o !== m_halt ||
                (e_valid && (instr_o !== e_instr || pc_o !== e_pc))) begin
                errors++;
                $display("FAIL random%0d valid=%b pc=%h instr=%h halted=%b want %b/%h/%h/%b",
                         i, instr_valid_o, pc_o, instr_o, halted_o, e_valid, e_pc, e_instr, m_halt);
            end
        end
        start_i = 0; stall_i = 0; redirect_i = 0; prog_we_i = 0;
    endtask

    initial begin
        test_reset();
        test_program();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
